instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, drives the instruction-memory read port and presents {PC+1, instruction, valid} to the IF/ID latch.
//  Handles downstream stall, branch/jump redirect (flush) and HLT.
//  Sits between instruction memory and the IF/ID pipeline register.
//  Counts retired fetches for the CPU performance output.
// PARAMETERS
//  WORD_SIZE  16     datapath/address width (matches opcodes.v)
//  RESET_PC   16'h0  PC value loaded on reset
//  BUBBLE     16'h0  instruction driven on if_instruction while if_valid=0
// PORTS
//  clk            in   1          clock, all state updates on posedge
//  reset_n        in   1          asynchronous, active-low reset
//  i_readM        out  1          instruction-memory read request
//  i_address      out  WORD_SIZE  instruction-memory address (= pc)
//  i_data         in   WORD_SIZE  instruction from memory, valid when i_inputReady=1
//  i_inputReady   in   1          memory read complete; data held while i_readM=1 and i_address is unchanged
//  stall          in   1          downstream cannot accept this cycle (hazard unit)
//  redirect       in   1          branch/jump resolved taken: flush and refetch
//  redirect_pc    in   WORD_SIZE  target PC when redirect=1
//  halt           in   1          HLT decoded: stop fetching until reset
//  if_pc          out  WORD_SIZE  PC+1 of the presented instruction
//  if_instruction out  WORD_SIZE  presented instruction (BUBBLE when invalid)
//  if_valid       out  1          if_pc/if_instruction hold a real instruction
//  fetch_count    out  WORD_SIZE  instructions accepted by downstream, wraps at 2^WORD_SIZE
// BEHAVIOUR
//  Reset (reset_n=0, async, immediate): pc=RESET_PC, state=IDLE, i_readM=0, if_valid=0, if_instruction=BUBBLE, if_pc=0, fetch_count=0.
//  Accept: the output slot is consumed at a posedge with if_valid=1 && stall=0 -> fetch_count+1 (mod 2^WORD_SIZE).
//  Slot free at a posedge = (!if_valid || !stall).
//  i_address = pc in every state; i_readM=1 only in FETCH and BLOCKED.
//  FSM (priority per posedge: redirect > halt > normal):
//   IDLE   : i_readM=0. Next: FETCH. Only one IDLE cycle after reset release.
//   FETCH  : i_readM=1.
//            i_inputReady && slot free -> if_instruction=i_data, if_pc=pc+1, if_valid=1, pc=pc+1, stay FETCH (back-to-back fetch, 1 instr/cycle with 0-latency memory).
//            i_inputReady && !slot free -> BLOCKED; pc/outputs unchanged.
//            !i_inputReady && slot free -> if_valid=0 (bubble), stay FETCH.
//   BLOCKED: i_readM=1, address held, so memory keeps i_data. When stall=0, capture as in FETCH -> FETCH.
//   FLUSH  : i_readM=0 for exactly one cycle to cancel any in-flight read. Next: FETCH at the new pc.
//   HALT   : i_readM=0, pc frozen. if_valid drops after the held instruction is accepted. Exit only by reset.
//  redirect=1 at a posedge (any state except IDLE):
//   - pc=redirect_pc, if_valid=0, if_instruction=BUBBLE, state=FLUSH.
//   - Same-cycle i_inputReady data is discarded.
//   - Overrides stall and halt.
//  halt=1 (no redirect): the current slot contents are kept; no new capture; state=HALT.
//  pc+1 wraps 16'hFFFF -> 16'h0000, with no flag.
//  reset_n low mid-read: i_readM falls immediately (async). No capture.
// TESTING
//  1 Reset then memory with 0 wait cycles, stall=0: i_readM rises 1 cycle after release.
//    if_pc sequence 1,2,3... one per cycle; fetch_count=5 after 5 accepts.
//  2 stall=1 for 3 cycles while if_valid=1 and i_inputReady=1: state BLOCKED.
//    i_address frozen, if_instruction unchanged, fetch_count unchanged.
//    stall=0 -> next instruction captured on the following edge.
//  3 redirect=1, redirect_pc=16'h0040, same edge as i_inputReady: data dropped, if_valid=0.
//    One cycle with i_readM=0, then i_address=16'h0040.
//  4 redirect and stall both high: redirect wins; flush occurs despite stall.
//  5 halt=1 with valid slot, stall=0: slot accepted, i_readM=0 thereafter, if_valid=0.
//    pc frozen for 20 cycles; reset restarts at RESET_PC.
//  6 pc=16'hFFFF fetched: if_pc=16'h0000 and next i_address=16'h0000.
//    Also: reset_n pulsed low mid-wait drops i_readM without waiting for clk.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory read
// port and presents {PC+1, instruction, valid} to the IF/ID latch. Handles
// downstream stall, taken branch/jump redirect (flush) and HLT, and counts
// instructions accepted by the downstream stage.
//
// Ports:
//   clk, reset_n                   clock / async active-low reset
//   i_readM, i_address             instruction-memory read request / address (= pc)
//   i_data, i_inputReady           instruction-memory read data / completion
//   stall                          downstream cannot accept this cycle
//   redirect, redirect_pc          taken branch/jump: flush and refetch at target
//   halt                           HLT decoded: stop fetching until reset
//   if_pc, if_instruction, if_valid  IF/ID payload (PC+1, instruction, valid)
//   fetch_count                    accepted instructions, wraps at 2^WORD_SIZE
module instruction_fetch_unit #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter logic [WORD_SIZE-1:0] BUBBLE    = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_inputReady,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic [WORD_SIZE-1:0] if_pc,
  output logic [WORD_SIZE-1:0] if_instruction,
  output logic                 if_valid,
  output logic [WORD_SIZE-1:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_BLOCKED,
    S_FLUSH,
    S_HALT
  } state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] pc_inc;
  logic                 accept;
  logic                 slot_free;
  logic                 redirect_hit;
  logic                 halt_hit;

  // The memory address is the PC register itself, so it is held for free
  // while a read is blocked.
  assign i_address    = pc;
  assign pc_inc       = pc + WORD_SIZE'(1);
  assign accept       = if_valid && !stall;
  assign slot_free    = !if_valid || !stall;
  // HALT is terminal: only reset leaves it, so a redirect there is ignored.
  assign redirect_hit = redirect && (state != S_IDLE) && (state != S_HALT);
  assign halt_hit     = (halt && (state != S_IDLE)) || (state == S_HALT);

  // Fetch FSM with registered read request and IF/ID payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      i_readM        <= 1'b0;
      if_pc          <= '0;
      if_instruction <= BUBBLE;
      if_valid       <= 1'b0;
      fetch_count    <= '0;
    end else begin
      if (accept) begin
        fetch_count <= fetch_count + WORD_SIZE'(1);
      end

      if (redirect_hit) begin
        // Same-edge read data is wrong-path and is dropped.
        state          <= S_FLUSH;
        pc             <= redirect_pc;
        i_readM        <= 1'b0;
        if_valid       <= 1'b0;
        if_instruction <= BUBBLE;
      end else if (halt_hit) begin
        // Keep the held instruction until downstream takes it, then go empty.
        state   <= S_HALT;
        i_readM <= 1'b0;
        if (accept) begin
          if_valid       <= 1'b0;
          if_instruction <= BUBBLE;
        end
      end else begin
        case (state)
          S_IDLE: begin
            state   <= S_FETCH;
            i_readM <= 1'b1;
          end
          S_FETCH: begin
            if (i_inputReady) begin
              if (slot_free) begin
                if_instruction <= i_data;
                if_pc          <= pc_inc;
                if_valid       <= 1'b1;
                pc             <= pc_inc;
              end else begin
                state <= S_BLOCKED;
              end
            end else if (slot_free) begin
              if_valid       <= 1'b0;
              if_instruction <= BUBBLE;
            end
          end
          S_BLOCKED: begin
            // Address has not moved, so memory is still presenting the data.
            if (!stall) begin
              state          <= S_FETCH;
              if_instruction <= i_data;
              if_pc          <= pc_inc;
              if_valid       <= 1'b1;
              pc             <= pc_inc;
            end
          end
          S_FLUSH: begin
            state   <= S_FETCH;
            i_readM <= 1'b1;
          end
          default: begin
            state   <= S_HALT;
            i_readM <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. Memory model: zero-wait, data is
// address ^ 16'hA5A5, ready gated by a bench enable.
module tb_instruction_fetch_unit;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_readM;
  logic [W-1:0] i_address;
  logic [W-1:0] i_data;
  logic         i_inputReady;
  logic         stall;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic         halt;
  logic [W-1:0] if_pc;
  logic [W-1:0] if_instruction;
  logic         if_valid;
  logic [W-1:0] fetch_count;
  logic         ready_en;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign i_data       = i_address ^ 16'hA5A5;
  assign i_inputReady = ready_en & i_readM;

  instruction_fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000), .BUBBLE(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .i_readM(i_readM), .i_address(i_address),
    .i_data(i_data), .i_inputReady(i_inputReady), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .if_pc(if_pc), .if_instruction(if_instruction), .if_valid(if_valid),
    .fetch_count(fetch_count)
  );

  task automatic test_reset();
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; ready_en = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (i_readM !== 1'b0) begin n_err++; $display("FAIL reset_readM got=%b exp=0", i_readM); end
    n_cmp++; if (i_address !== 16'h0000) begin n_err++; $display("FAIL reset_addr got=%h exp=0000", i_address); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    n_cmp++; if (if_instruction !== 16'h0000) begin n_err++; $display("FAIL reset_instr got=%h exp=0000", if_instruction); end
    n_cmp++; if (if_pc !== 16'h0000) begin n_err++; $display("FAIL reset_ifpc got=%h exp=0000", if_pc); end
    n_cmp++; if (fetch_count !== 16'h0000) begin n_err++; $display("FAIL reset_count got=%h exp=0000", fetch_count); end
  endtask

  // Release reset: one IDLE cycle, then one instruction per cycle.
  task automatic test_stream();
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (i_readM !== 1'b1) begin n_err++; $display("FAIL stream_readM_rise got=%b exp=1", i_readM); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL stream_idle_valid got=%b exp=0", if_valid); end
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      n_cmp++; if (if_pc !== W'(k - 1)) begin n_err++; $display("FAIL stream_ifpc[%0d] got=%h exp=%h", k, if_pc, W'(k - 1)); end
      n_cmp++; if (if_instruction !== (W'(k - 2) ^ 16'hA5A5)) begin n_err++; $display("FAIL stream_instr[%0d] got=%h exp=%h", k, if_instruction, W'(k - 2) ^ 16'hA5A5); end
      n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got=%b exp=1", k, if_valid); end
      n_cmp++; if (fetch_count !== W'(k - 2)) begin n_err++; $display("FAIL stream_count[%0d] got=%0d exp=%0d", k, fetch_count, k - 2); end
    end
  endtask

  // Slot holds addr 5 (if_pc=6), pc=6, count=5.
  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (i_address !== 16'h0006) begin n_err++; $display("FAIL stall_addr[%0d] got=%h exp=0006", k, i_address); end
      n_cmp++; if (if_instruction !== (16'h0005 ^ 16'hA5A5)) begin n_err++; $display("FAIL stall_instr[%0d] got=%h exp=%h", k, if_instruction, 16'h0005 ^ 16'hA5A5); end
      n_cmp++; if (fetch_count !== 16'd5) begin n_err++; $display("FAIL stall_count[%0d] got=%0d exp=5", k, fetch_count); end
      n_cmp++; if (i_readM !== 1'b1) begin n_err++; $display("FAIL stall_readM[%0d] got=%b exp=1", k, i_readM); end
    end
    stall = 1'b0;
    @(negedge clk);
    n_cmp++; if (if_pc !== 16'h0007) begin n_err++; $display("FAIL unstall_ifpc got=%h exp=0007", if_pc); end
    n_cmp++; if (if_instruction !== (16'h0006 ^ 16'hA5A5)) begin n_err++; $display("FAIL unstall_instr got=%h exp=%h", if_instruction, 16'h0006 ^ 16'hA5A5); end
    n_cmp++; if (fetch_count !== 16'd6) begin n_err++; $display("FAIL unstall_count got=%0d exp=6", fetch_count); end
  endtask

  // Redirect on the same edge as ready data; the valid slot is still accepted.
  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    n_cmp++; if (i_readM !== 1'b0) begin n_err++; $display("FAIL redir_readM got=%b exp=0", i_readM); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid got=%b exp=0", if_valid); end
    n_cmp++; if (if_instruction !== 16'h0000) begin n_err++; $display("FAIL redir_instr got=%h exp=0000", if_instruction); end
    n_cmp++; if (i_address !== 16'h0040) begin n_err++; $display("FAIL redir_addr got=%h exp=0040", i_address); end
    n_cmp++; if (fetch_count !== 16'd7) begin n_err++; $display("FAIL redir_count got=%0d exp=7", fetch_count); end
    @(negedge clk);
    n_cmp++; if (i_readM !== 1'b1) begin n_err++; $display("FAIL redir_refetch_readM got=%b exp=1", i_readM); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush_valid got=%b exp=0", if_valid); end
    @(negedge clk);
    n_cmp++; if (if_pc !== 16'h0041) begin n_err++; $display("FAIL redir_ifpc got=%h exp=0041", if_pc); end
    n_cmp++; if (if_instruction !== (16'h0040 ^ 16'hA5A5)) begin n_err++; $display("FAIL redir_target_instr got=%h exp=%h", if_instruction, 16'h0040 ^ 16'hA5A5); end
    @(negedge clk);
    n_cmp++; if (if_pc !== 16'h0042 || fetch_count !== 16'd8) begin n_err++; $display("FAIL redir_next got=%h/%0d exp=0042/8", if_pc, fetch_count); end
  endtask

  // Redirect and stall together: flush wins, stalled slot is not counted.
  task automatic test_redirect_stall();
    redirect = 1'b1; stall = 1'b1; redirect_pc = 16'h0080;
    @(negedge clk);
    redirect = 1'b0; stall = 1'b0;
    n_cmp++; if (i_address !== 16'h0080) begin n_err++; $display("FAIL rs_addr got=%h exp=0080", i_address); end
    n_cmp++; if (if_valid !== 1'b0 || i_readM !== 1'b0) begin n_err++; $display("FAIL rs_flush got=v%b/r%b exp=v0/r0", if_valid, i_readM); end
    n_cmp++; if (fetch_count !== 16'd8) begin n_err++; $display("FAIL rs_count got=%0d exp=8", fetch_count); end
    repeat (2) @(negedge clk);
    n_cmp++; if (if_pc !== 16'h0081 || if_valid !== 1'b1) begin n_err++; $display("FAIL rs_refetch got=%h/%b exp=0081/1", if_pc, if_valid); end
  endtask

  // PC wrap at FFFF, then reset asserted while a read is waiting.
  task automatic test_wrap_and_async_reset();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge clk);
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (if_pc !== 16'h0000) begin n_err++; $display("FAIL wrap_ifpc got=%h exp=0000", if_pc); end
    n_cmp++; if (if_instruction !== 16'h5A5A) begin n_err++; $display("FAIL wrap_instr got=%h exp=5A5A", if_instruction); end
    n_cmp++; if (i_address !== 16'h0000) begin n_err++; $display("FAIL wrap_addr got=%h exp=0000", i_address); end
    n_cmp++; if (fetch_count !== 16'd9) begin n_err++; $display("FAIL wrap_count got=%0d exp=9", fetch_count); end
    @(negedge clk);
    n_cmp++; if (if_pc !== 16'h0001) begin n_err++; $display("FAIL wrap_next_ifpc got=%h exp=0001", if_pc); end
    ready_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (if_valid !== 1'b0 || i_readM !== 1'b1) begin n_err++; $display("FAIL wait_bubble got=v%b/r%b exp=v0/r1", if_valid, i_readM); end
    n_cmp++; if (fetch_count !== 16'd11) begin n_err++; $display("FAIL wait_count got=%0d exp=11", fetch_count); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (i_readM !== 1'b0) begin n_err++; $display("FAIL async_readM got=%b exp=0", i_readM); end
    n_cmp++; if (fetch_count !== 16'd0 || i_address !== 16'h0000) begin n_err++; $display("FAIL async_state got=%0d/%h exp=0/0000", fetch_count, i_address); end
    ready_en = 1'b1;
    @(negedge clk);
  endtask

  // HALT with a valid slot and no stall: slot drains, pc frozen until reset.
  task automatic test_halt();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (if_pc !== 16'h0002 || fetch_count !== 16'd1) begin n_err++; $display("FAIL halt_pre got=%h/%0d exp=0002/1", if_pc, fetch_count); end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    n_cmp++; if (fetch_count !== 16'd2) begin n_err++; $display("FAIL halt_accept got=%0d exp=2", fetch_count); end
    n_cmp++; if (if_valid !== 1'b0 || i_readM !== 1'b0) begin n_err++; $display("FAIL halt_drop got=v%b/r%b exp=v0/r0", if_valid, i_readM); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++; if (i_address !== 16'h0002 || i_readM !== 1'b0 || if_valid !== 1'b0 || fetch_count !== 16'd2) begin
        n_err++; $display("FAIL halt_frozen[%0d] got=a%h r%b v%b c%0d exp=a0002 r0 v0 c2", k, i_address, i_readM, if_valid, fetch_count);
      end
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (i_readM !== 1'b1 || i_address !== 16'h0000) begin n_err++; $display("FAIL halt_restart got=r%b a%h exp=r1 a0000", i_readM, i_address); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap_and_async_reset();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
